// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared memory bus (port 0 = core, port 1 = host loader/debug).
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin IDLE tie-break; default is port-0 priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  input  logic [1:0]        mode0_i,
  input  logic [1:0]        mode1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [DATA_W-1:0] mem_value_i,
  output logic [1:0]        mem_mode_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_value_o
);

  localparam logic [1:0] MEM_READ = 2'b00;
  localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
  logic              hold_hit;
  logic              gnt0, gnt1, xfer, sel_lock;
  logic [1:0]        sel_mode;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_pend_q, rd_tag_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        mem_mode_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_write_value_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Grant (output) logic
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
          gnt0 = ~rr_ptr_q;
          gnt1 = rr_ptr_q;
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = req0_i;
          gnt1 = req1_i;
        end
      end
      StLock0: gnt0 = req0_i;
      StLock1: gnt1 = req1_i;
      default: ;
    endcase
  end

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign xfer      = gnt0 | gnt1;
  assign sel_lock  = gnt1 ? lock1_i : lock0_i;
  assign sel_mode  = gnt1 ? mode1_i : mode0_i;
  assign sel_addr  = gnt1 ? addr1_i : addr0_i;
  assign sel_wdata = gnt1 ? wdata1_i : wdata0_i;
  assign hold_inc  = hold_cnt_q + 1'b1;
  assign hold_hit  = (HOLD_MAX != 0) && (hold_inc == CntW'(HOLD_MAX));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (xfer) rr_ptr_d = gnt0;
`endif
        // The locking transfer itself counts toward the hold budget.
        if (xfer && sel_lock) begin
          if (hold_hit) begin
            hold_cnt_d = '0;
          end else begin
            state_d    = gnt1 ? StLock1 : StLock0;
            hold_cnt_d = hold_inc;
          end
        end
      end
      StLock0, StLock1: begin
        if (xfer && hold_hit) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d   = (state_q == StLock0);
`endif
        end else if (!((state_q == StLock0) ? lock0_i : lock1_i)) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end else if (xfer) begin
          hold_cnt_d = hold_inc;
        end
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Memory bus and read-return datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_mode_q        <= MEM_READ;
      mem_address_q     <= '0;
      mem_write_value_q <= '0;
      rd_pend_q         <= 1'b0;
      rd_tag_q          <= 1'b0;
      rvalid0_q         <= 1'b0;
      rvalid1_q         <= 1'b0;
      rdata0_q          <= '0;
      rdata1_q          <= '0;
    end else begin
      if (xfer) begin
        mem_mode_q        <= sel_mode;
        mem_address_q     <= sel_addr;
        mem_write_value_q <= sel_wdata;
      end else begin
        mem_mode_q        <= MEM_READ;
        mem_write_value_q <= '0;
      end
      rd_pend_q <= xfer && (sel_mode == MEM_READ);
      rd_tag_q  <= gnt1;
      rvalid0_q <= rd_pend_q & ~rd_tag_q;
      rvalid1_q <= rd_pend_q & rd_tag_q;
      if (rd_pend_q && !rd_tag_q) rdata0_q <= mem_value_i;
      if (rd_pend_q && rd_tag_q)  rdata1_q <= mem_value_i;
    end
  end

  assign mem_mode_o        = mem_mode_q;
  assign mem_address_o     = mem_address_q;
  assign mem_write_value_o = mem_write_value_q;
  assign rvalid0_o         = rvalid0_q;
  assign rvalid1_o         = rvalid1_q;
  assign rdata0_o          = rdata0_q;
  assign rdata1_o          = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; read responses are tracked with an in-order scoreboard.
// A second instance with HOLD_MAX=2 exercises forced lock release.
module tb_mem_bus_arbiter;

  localparam logic [1:0] MEM_READ       = 2'b00;
  localparam logic [1:0] MEM_WRITE_WORD = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rsp_t;

  logic        clk, rst;
  logic        req0, req1, lock0, lock1;
  logic [1:0]  mode0, mode1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, mem_value, mem_write_value;
  logic [1:0]  mem_mode;
  logic [7:0]  mem_address;
  logic        h_gnt0, h_gnt1, h_rvalid0, h_rvalid1;
  logic [31:0] h_rdata0, h_rdata1, h_mem_value, h_mem_write_value;
  logic [1:0]  h_mem_mode;
  logic [7:0]  h_mem_address;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  rsp_t mon_e;
  logic exp1;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {8'hC0, a, ~a, a};
  endfunction

  assign mem_value   = mem_word(mem_address);
  assign h_mem_value = mem_word(h_mem_address);

  mem_bus_arbiter u_dut (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .mode0_i(mode0), .mode1_i(mode1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_value_i(mem_value), .mem_mode_o(mem_mode), .mem_address_o(mem_address),
    .mem_write_value_o(mem_write_value)
  );

  mem_bus_arbiter #(.HOLD_MAX(2)) u_hold (
    .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .mode0_i(mode0), .mode1_i(mode1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt0_o(h_gnt0), .gnt1_o(h_gnt1),
    .rvalid0_o(h_rvalid0), .rvalid1_o(h_rvalid1), .rdata0_o(h_rdata0), .rdata1_o(h_rdata1),
    .mem_value_i(h_mem_value), .mem_mode_o(h_mem_mode), .mem_address_o(h_mem_address),
    .mem_write_value_o(h_mem_write_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    mode0 = MEM_READ; mode1 = MEM_READ;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst && (rvalid0 || rvalid1)) begin
      check("rsp_outstanding", 32'(sb.size() > 0), 32'd1);
      check("rsp_single_port", 32'(rvalid0 & rvalid1), 32'd0);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("rsp_port", 32'(rvalid1), 32'(mon_e.port));
        check("rsp_data", rvalid1 ? rdata1 : rdata0, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("rst_mem_mode", 32'(mem_mode), 32'(MEM_READ));
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wval", mem_write_value, 32'd0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    rst = 1'b0;

    // Single read from port 0
    @(negedge clk); req0 = 1'b1; addr0 = 8'h10; #1;
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_gnt1", 32'(gnt1), 32'd0);
    sb.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    @(posedge clk); #1;
    check("rd_bus_addr", 32'(mem_address), 32'h10);
    check("rd_bus_mode", 32'(mem_mode), 32'(MEM_READ));
    @(negedge clk); req0 = 1'b0;
    @(posedge clk); #1;
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    check("rd_rvalid1", 32'(rvalid1), 32'd0);
    @(posedge clk); #1;
    check("rd_rvalid0_pulse", 32'(rvalid0), 32'd0);
    check("rd_rdata0_held", rdata0, 32'hDEAD_BEEF);

    // Reset while a read is in flight
    @(negedge clk); req0 = 1'b1; addr0 = 8'h30; #1;
    check("rstrd_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    check("rstrd_bus_addr", 32'(mem_address), 32'h30);
    @(negedge clk); req0 = 1'b0; rst = 1'b1; #1;
    check("rstrd_addr_clr", 32'(mem_address), 32'd0);
    check("rstrd_mode", 32'(mem_mode), 32'(MEM_READ));
    @(posedge clk); #1;
    check("rstrd_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rstrd_no_rvalid_late", {30'd0, rvalid1, rvalid0}, 32'd0);

    // Both ports requesting in IDLE for four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req0 = 1'b1; req1 = 1'b1; addr0 = 8'h40; addr1 = 8'h44; #1;
      exp1 = RR && (i % 2 == 1);
      check($sformatf("tie_gnt0_%0d", i), 32'(gnt0), 32'(!exp1));
      check($sformatf("tie_gnt1_%0d", i), 32'(gnt1), 32'(exp1));
      sb.push_back('{port: exp1, data: mem_word(exp1 ? 8'h44 : 8'h40)});
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    check("tie_drained", 32'(sb.size()), 32'd0);

    // Interleaved reads on consecutive edges
    @(negedge clk); req0 = 1'b1; addr0 = 8'h20; #1;
    check("il_gnt0", 32'(gnt0), 32'd1);
    sb.push_back('{port: 1'b0, data: mem_word(8'h20)});
    @(negedge clk); req0 = 1'b0; req1 = 1'b1; addr1 = 8'h24; #1;
    check("il_gnt1", 32'(gnt1), 32'd1);
    sb.push_back('{port: 1'b1, data: mem_word(8'h24)});
    @(posedge clk); #1;
    check("il_rvalid0", 32'(rvalid0), 32'd1);
    check("il_rdata0", rdata0, mem_word(8'h20));
    check("il_rvalid1_early", 32'(rvalid1), 32'd0);
    @(negedge clk); req1 = 1'b0;
    @(posedge clk); #1;
    check("il_rvalid1", 32'(rvalid1), 32'd1);
    check("il_rdata1", rdata1, mem_word(8'h24));
    check("il_rvalid0_late", 32'(rvalid0), 32'd0);

    // Port 1 locked three-beat word write while port 0 waits
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req0 = (b > 0); addr0 = 8'h50;
      req1 = 1'b1; lock1 = (b < 2); mode1 = MEM_WRITE_WORD;
      addr1 = 8'(4 * b); wdata1 = 32'h1111_1111 * (b + 1); #1;
      check($sformatf("burst_gnt1_%0d", b), 32'(gnt1), 32'd1);
      check($sformatf("burst_gnt0_%0d", b), 32'(gnt0), 32'd0);
      @(posedge clk); #1;
      check($sformatf("burst_mode_%0d", b), 32'(mem_mode), 32'(MEM_WRITE_WORD));
      check($sformatf("burst_addr_%0d", b), 32'(mem_address), 32'(4 * b));
      check($sformatf("burst_wval_%0d", b), mem_write_value, 32'h1111_1111 * (b + 1));
    end
    @(negedge clk); req1 = 1'b0; lock1 = 1'b0; mode1 = MEM_READ; #1;
    check("burst_gnt0_after", 32'(gnt0), 32'd1);
    sb.push_back('{port: 1'b0, data: mem_word(8'h50)});
    @(posedge clk); #1;
    check("burst_idle_mode", 32'(mem_mode), 32'(MEM_READ));
    check("burst_idle_wval", mem_write_value, 32'd0);
    check("burst_rd_addr", 32'(mem_address), 32'h50);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    check("burst_drained", 32'(sb.size()), 32'd0);

    // Forced release after HOLD_MAX locked transfers (u_hold: 2, u_dut: 16)
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; lock0 = 1'b1; addr0 = 8'h60; req1 = 1'b1; addr1 = 8'h64; #1;
    check("hold_h_gnt0_0", 32'(h_gnt0), 32'd1);
    check("hold_h_gnt1_0", 32'(h_gnt1), 32'd0);
    check("hold_gnt0_0", 32'(gnt0), 32'd1);
    sb.push_back('{port: 1'b0, data: mem_word(8'h60)});
    @(negedge clk); #1;
    check("hold_h_gnt0_1", 32'(h_gnt0), 32'd1);
    check("hold_h_gnt1_1", 32'(h_gnt1), 32'd0);
    check("hold_gnt1_1", 32'(gnt1), 32'd0);
    sb.push_back('{port: 1'b0, data: mem_word(8'h60)});
    // Without round-robin port 0 would retake the tie, so it backs off to expose the release.
    @(negedge clk); if (!RR) req0 = 1'b0; #1;
    check("hold_h_gnt1_rel", 32'(h_gnt1), 32'd1);
    check("hold_h_gnt0_rel", 32'(h_gnt0), 32'd0);
    check("hold_gnt1_still_locked", 32'(gnt1), 32'd0);
    check("hold_gnt0_still_locked", 32'(gnt0), 32'(RR));
    if (gnt0) sb.push_back('{port: 1'b0, data: mem_word(8'h60)});
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    check("hold_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
